l2_tlb_ctrl: RTL and testbench
==============================

Name: l2_tlb_ctrl

Overview:
Sequencing controller for the shared second-level TLB. It takes translation misses from the I-TLB and D-TLB and grants one per turn by round-robin. It issues the L2 array lookup and, on an L2 miss, runs one page-table walk through the PTW port, refills the L2 array, then returns the PTE to the requester that owns the transaction. It drives the hit/miss select of the L2 return-path mux and is the only master of the PTW request port on the L2 side.

Parameters:
VPN_W, 27, virtual page number width
PPN_W, 20, physical page number width
PERM_W, 6, permission bits packed {d,r,x,w,u,v}

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
io_itlb_req_valid  in  1  I-TLB miss request
io_itlb_req_ready  out  1  I-TLB request accepted
io_itlb_req_vpn  in  VPN_W  I-TLB VPN
io_dtlb_req_valid  in  1  D-TLB miss request
io_dtlb_req_ready  out  1  D-TLB request accepted
io_dtlb_req_vpn  in  VPN_W  D-TLB VPN
io_itlb_resp_valid  out  1  response pulse to I-TLB
io_dtlb_resp_valid  out  1  response pulse to D-TLB
io_resp_pte_ppn  out  PPN_W  returned PPN, shared by both requesters
io_resp_pte_perm  out  PERM_W  returned permissions, shared
l2_lookup_valid  out  1  L2 array read strobe
l2_lookup_vpn  out  VPN_W  L2 array read VPN
l2_tlb_miss  in  1  L2 miss, valid the cycle after the strobe
l2_resp_ppn  in  PPN_W  L2 hit PPN, same timing as l2_tlb_miss
l2_resp_perm  in  PERM_W  L2 hit permissions
l2_refill_valid  out  1  L2 array write strobe
l2_refill_vpn  out  VPN_W  refill VPN
l2_refill_ppn  out  PPN_W  refill PPN
l2_refill_perm  out  PERM_W  refill permissions
io_ptw_req_valid  out  1  walk request
io_ptw_req_ready  in  1  PTW accepts request
io_ptw_req_bits_addr  out  VPN_W  walk VPN
io_ptw_resp_valid  in  1  walk done
io_ptw_resp_bits_pte_ppn  in  PPN_W  walked PPN
io_ptw_resp_bits_pte_perm  in  PERM_W  walked permissions
io_flush  in  1  sfence/ASID flush, one-cycle pulse

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Round-robin pointer = D-TLB priority.
  - flush_pending = 0.
  - Owner register = D-TLB.
- States: IDLE, LOOKUP, WALK_REQ, WALK_WAIT, RESP. One transaction in flight at a time.
- IDLE:
  - Arbiter grants one valid requester and drives ready=1 only to that requester.
  - On one request, grant it. On a tie, grant the side the pointer favours; the pointer then flips to the other side.
  - On grant: l2_lookup_valid=1 and l2_lookup_vpn = granted VPN (combinational), same cycle. Latch VPN and owner, then go to LOOKUP.
- Ready is 0 in every non-IDLE state. The requester holds valid/vpn until ready.
- LOOKUP:
  - Sample l2_tlb_miss.
  - Hit: latch l2_resp_ppn/perm, go to RESP.
  - Miss: go to WALK_REQ.
- WALK_REQ: io_ptw_req_valid=1, addr = latched VPN. On ready, go to WALK_WAIT. Valid may be asserted for several cycles; addr stays stable.
- WALK_WAIT:
  - Wait for io_ptw_resp_valid, then latch PTE and go to RESP.
  - In that same cycle, register the refill so that l2_refill_valid=1 for exactly the RESP cycle, with latched vpn/ppn/perm.
  - Refill is suppressed when flush_pending=1, or when the flush arrives in the same cycle, or when the PTE v bit is 0.
- RESP:
  - Exactly one cycle, with the owner's resp_valid=1 and io_resp_pte_* = latched PTE. Requesters cannot stall.
  - Then go to IDLE.
- Latency:
  - Hit: accept at cycle T, resp_valid at T+2.
  - Miss: resp_valid one cycle after the io_ptw_resp_valid cycle.
- Flush:
  - Sets flush_pending in any non-IDLE state. It clears on entry to IDLE.
  - The in-flight response is still delivered.
  - A flush in IDLE has no effect.
- io_ptw_resp_valid outside WALK_WAIT is ignored.
- Reset mid-walk: synchronous return to IDLE. The outstanding walk is abandoned and its later response is ignored.
- The L2 hit/miss return mux select is the registered state (LOOKUP-hit versus WALK path). No combinational path from io_ptw_resp to io_resp_*.

Decomposition:
- Shared package l2_tlb_pkg holds:
  - the state enum;
  - VPN_W, PPN_W, PERM_W;
  - permission bit indices V=0, U=1, W=2, X=3, R=4, D=5.
- One natural sub-module: l2_tlb_rr_arb, a 2-input round-robin arbiter with grant and pointer update on accept.
- The FSM and datapath latches stay in l2_tlb_ctrl.

Test Plan:
- L2 hit:
  - Stimulus: D-TLB vpn=0x12345 at T; l2_tlb_miss=0, ppn=0xABCDE, perm=0x3F.
  - Expected: dtlb_resp_valid at T+2 with ppn=0xABCDE, perm=0x3F. No ptw_req_valid, no refill.
- L2 miss:
  - Stimulus: I-TLB vpn=0x00777; PTW ready after 3 cycles; ptw_resp 5 cycles later with ppn=0x00042, perm=0x1F.
  - Expected: exactly one walk with addr=0x00777. itlb_resp_valid with ppn 0x00042. l2_refill_valid for that same single cycle, with vpn=0x00777.
- Tie fairness:
  - Stimulus: both requesters valid continuously, each request a hit.
  - Expected: grants alternate D, I, D, I starting with D after reset. Each resp_valid goes only to its owner.
- Flush during walk:
  - Stimulus: io_flush pulse in WALK_WAIT, then walk returns ppn=0x00099.
  - Expected: response delivered with ppn 0x00099. l2_refill_valid stays 0.
- Invalid PTE:
  - Stimulus: walk returns perm v=0.
  - Expected: response delivered with v=0, no refill.
- Reset mid-walk:
  - Stimulus: reset asserted during WALK_WAIT, then ptw_resp_valid=1 after reset.
  - Expected: all outputs 0, no resp_valid, no refill. The next request is serviced normally.

Source files
------------

// File: rtl/l2_tlb_pkg.sv
// Shared types and widths for the L2 TLB sequencing controller.
package l2_tlb_pkg;

  localparam int VPN_W  = 27;
  localparam int PPN_W  = 20;
  localparam int PERM_W = 6;

  // Permission bit positions inside the packed {d,r,x,w,u,v} field.
  localparam int BIT_V = 0;
  localparam int BIT_U = 1;
  localparam int BIT_W = 2;
  localparam int BIT_X = 3;
  localparam int BIT_R = 4;
  localparam int BIT_D = 5;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_WALK_REQ  = 3'd2,
    S_WALK_WAIT = 3'd3,
    S_RESP      = 3'd4
  } state_e;

  typedef enum logic {
    OWN_D = 1'b0,
    OWN_I = 1'b1
  } owner_e;

  function automatic logic pte_valid(input logic [PERM_W-1:0] perm);
    return perm[BIT_V];
  endfunction

endpackage

// File: rtl/l2_tlb_rr_arb.sv
// Two-input round-robin arbiter between the I-TLB and D-TLB miss requests.
module l2_tlb_rr_arb
  import l2_tlb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req_i,
  input  logic req_d,
  output logic gnt_i,
  output logic gnt_d
);

  // ptr_q = OWN_D means a tie goes to the D-TLB.
  owner_e ptr_q;
  owner_e ptr_d;

  // Grant selection and pointer advance to the side that lost this turn.
  always_comb begin
    gnt_d = en & req_d & (~req_i | (ptr_q == OWN_D));
    gnt_i = en & req_i & (~req_d | (ptr_q == OWN_I));
    if (gnt_d) begin
      ptr_d = OWN_I;
    end else if (gnt_i) begin
      ptr_d = OWN_D;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= OWN_D;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/l2_tlb_ctrl.sv
// L2 TLB sequencer: arbitrates I/D misses, looks up the L2 array, walks on a
// miss, refills the array and returns the PTE to the owning requester.
module l2_tlb_ctrl
  import l2_tlb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              io_itlb_req_valid,
  output logic              io_itlb_req_ready,
  input  logic [VPN_W-1:0]  io_itlb_req_vpn,
  input  logic              io_dtlb_req_valid,
  output logic              io_dtlb_req_ready,
  input  logic [VPN_W-1:0]  io_dtlb_req_vpn,
  output logic              io_itlb_resp_valid,
  output logic              io_dtlb_resp_valid,
  output logic [PPN_W-1:0]  io_resp_pte_ppn,
  output logic [PERM_W-1:0] io_resp_pte_perm,
  output logic              l2_lookup_valid,
  output logic [VPN_W-1:0]  l2_lookup_vpn,
  input  logic              l2_tlb_miss,
  input  logic [PPN_W-1:0]  l2_resp_ppn,
  input  logic [PERM_W-1:0] l2_resp_perm,
  output logic              l2_refill_valid,
  output logic [VPN_W-1:0]  l2_refill_vpn,
  output logic [PPN_W-1:0]  l2_refill_ppn,
  output logic [PERM_W-1:0] l2_refill_perm,
  output logic              io_ptw_req_valid,
  input  logic              io_ptw_req_ready,
  output logic [VPN_W-1:0]  io_ptw_req_bits_addr,
  input  logic              io_ptw_resp_valid,
  input  logic [PPN_W-1:0]  io_ptw_resp_bits_pte_ppn,
  input  logic [PERM_W-1:0] io_ptw_resp_bits_pte_perm,
  input  logic              io_flush
);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [VPN_W-1:0]    vpn_q, vpn_d;
  logic [PPN_W-1:0]    ppn_q, ppn_d;
  logic [PERM_W-1:0]   perm_q, perm_d;
  logic                flush_pending_q, flush_pending_d;
  logic                refill_valid_q, refill_valid_d;

  logic                gnt_i, gnt_d, grant_any;
  logic [VPN_W-1:0]    grant_vpn;

  l2_tlb_rr_arb u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == S_IDLE),
    .req_i (io_itlb_req_valid),
    .req_d (io_dtlb_req_valid),
    .gnt_i (gnt_i),
    .gnt_d (gnt_d)
  );

  assign grant_any = gnt_i | gnt_d;
  assign grant_vpn = gnt_i ? io_itlb_req_vpn : io_dtlb_req_vpn;

  assign io_itlb_req_ready = gnt_i;
  assign io_dtlb_req_ready = gnt_d;
  assign l2_lookup_valid   = grant_any;
  assign l2_lookup_vpn     = grant_any ? grant_vpn : {VPN_W{1'b0}};

  assign io_ptw_req_valid     = (state_q == S_WALK_REQ);
  assign io_ptw_req_bits_addr = (state_q == S_WALK_REQ) ? vpn_q : {VPN_W{1'b0}};

  // The response is only visible in RESP; ppn_q/perm_q hold either the L2 hit or walk result.
  assign io_itlb_resp_valid = (state_q == S_RESP) && (owner_q == OWN_I);
  assign io_dtlb_resp_valid = (state_q == S_RESP) && (owner_q == OWN_D);
  assign io_resp_pte_ppn    = (state_q == S_RESP) ? ppn_q  : {PPN_W{1'b0}};
  assign io_resp_pte_perm   = (state_q == S_RESP) ? perm_q : {PERM_W{1'b0}};

  assign l2_refill_valid = refill_valid_q;
  assign l2_refill_vpn   = refill_valid_q ? vpn_q  : {VPN_W{1'b0}};
  assign l2_refill_ppn   = refill_valid_q ? ppn_q  : {PPN_W{1'b0}};
  assign l2_refill_perm  = refill_valid_q ? perm_q : {PERM_W{1'b0}};

  // Next-state and datapath latch logic for the single in-flight transaction.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    vpn_d          = vpn_q;
    ppn_d          = ppn_q;
    perm_d         = perm_q;
    refill_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          vpn_d   = grant_vpn;
          owner_d = gnt_i ? OWN_I : OWN_D;
          state_d = S_LOOKUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOOKUP: begin
        if (!l2_tlb_miss) begin
          ppn_d   = l2_resp_ppn;
          perm_d  = l2_resp_perm;
          state_d = S_RESP;
        end else begin
          state_d = S_WALK_REQ;
        end
      end
      S_WALK_REQ: begin
        if (io_ptw_req_ready) begin
          state_d = S_WALK_WAIT;
        end else begin
          state_d = S_WALK_REQ;
        end
      end
      S_WALK_WAIT: begin
        if (io_ptw_resp_valid) begin
          ppn_d          = io_ptw_resp_bits_pte_ppn;
          perm_d         = io_ptw_resp_bits_pte_perm;
          refill_valid_d = !flush_pending_q && !io_flush &&
                           pte_valid(io_ptw_resp_bits_pte_perm);
          state_d        = S_RESP;
        end else begin
          state_d = S_WALK_WAIT;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_IDLE) begin
      flush_pending_d = 1'b0;
    end else if ((state_q != S_IDLE) && io_flush) begin
      flush_pending_d = 1'b1;
    end else begin
      flush_pending_d = flush_pending_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      owner_q         <= OWN_D;
      vpn_q           <= {VPN_W{1'b0}};
      ppn_q           <= {PPN_W{1'b0}};
      perm_q          <= {PERM_W{1'b0}};
      flush_pending_q <= 1'b0;
      refill_valid_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      vpn_q           <= vpn_d;
      ppn_q           <= ppn_d;
      perm_q          <= perm_d;
      flush_pending_q <= flush_pending_d;
      refill_valid_q  <= refill_valid_d;
    end
  end

endmodule

// File: tb/tb_l2_tlb_ctrl.sv
// Directed self-checking bench for l2_tlb_ctrl.
module tb_l2_tlb_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_itlb_req_valid, io_itlb_req_ready;
  logic [26:0] io_itlb_req_vpn;
  logic        io_dtlb_req_valid, io_dtlb_req_ready;
  logic [26:0] io_dtlb_req_vpn;
  logic        io_itlb_resp_valid, io_dtlb_resp_valid;
  logic [19:0] io_resp_pte_ppn;
  logic [5:0]  io_resp_pte_perm;
  logic        l2_lookup_valid;
  logic [26:0] l2_lookup_vpn;
  logic        l2_tlb_miss;
  logic [19:0] l2_resp_ppn;
  logic [5:0]  l2_resp_perm;
  logic        l2_refill_valid;
  logic [26:0] l2_refill_vpn;
  logic [19:0] l2_refill_ppn;
  logic [5:0]  l2_refill_perm;
  logic        io_ptw_req_valid, io_ptw_req_ready;
  logic [26:0] io_ptw_req_bits_addr;
  logic        io_ptw_resp_valid;
  logic [19:0] io_ptw_resp_bits_pte_ppn;
  logic [5:0]  io_ptw_resp_bits_pte_perm;
  logic        io_flush;

  int vectors = 0;
  int miscompares = 0;
  int walk_cnt = 0;
  int refill_cnt = 0;

  always #5 clk = ~clk;

  l2_tlb_ctrl dut (
    .clk(clk), .reset(reset),
    .io_itlb_req_valid(io_itlb_req_valid), .io_itlb_req_ready(io_itlb_req_ready),
    .io_itlb_req_vpn(io_itlb_req_vpn),
    .io_dtlb_req_valid(io_dtlb_req_valid), .io_dtlb_req_ready(io_dtlb_req_ready),
    .io_dtlb_req_vpn(io_dtlb_req_vpn),
    .io_itlb_resp_valid(io_itlb_resp_valid), .io_dtlb_resp_valid(io_dtlb_resp_valid),
    .io_resp_pte_ppn(io_resp_pte_ppn), .io_resp_pte_perm(io_resp_pte_perm),
    .l2_lookup_valid(l2_lookup_valid), .l2_lookup_vpn(l2_lookup_vpn),
    .l2_tlb_miss(l2_tlb_miss), .l2_resp_ppn(l2_resp_ppn), .l2_resp_perm(l2_resp_perm),
    .l2_refill_valid(l2_refill_valid), .l2_refill_vpn(l2_refill_vpn),
    .l2_refill_ppn(l2_refill_ppn), .l2_refill_perm(l2_refill_perm),
    .io_ptw_req_valid(io_ptw_req_valid), .io_ptw_req_ready(io_ptw_req_ready),
    .io_ptw_req_bits_addr(io_ptw_req_bits_addr),
    .io_ptw_resp_valid(io_ptw_resp_valid),
    .io_ptw_resp_bits_pte_ppn(io_ptw_resp_bits_pte_ppn),
    .io_ptw_resp_bits_pte_perm(io_ptw_resp_bits_pte_perm),
    .io_flush(io_flush)
  );

  wire any_out = |{io_itlb_req_ready, io_dtlb_req_ready, io_itlb_resp_valid,
                   io_dtlb_resp_valid, io_resp_pte_ppn, io_resp_pte_perm,
                   l2_lookup_valid, l2_lookup_vpn, l2_refill_valid, l2_refill_vpn,
                   l2_refill_ppn, l2_refill_perm, io_ptw_req_valid, io_ptw_req_bits_addr};

  // Handshake monitor: counts accepted walks and refill cycles.
  always @(posedge clk) begin
    if (io_ptw_req_valid && io_ptw_req_ready) walk_cnt <= walk_cnt + 1;
    if (l2_refill_valid) refill_cnt <= refill_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One full transaction. flush_mode: 0 none, 1 early in WALK_WAIT, 2 with the walk response.
  task automatic do_txn(input bit side_i, input logic [26:0] vpn, input bit miss,
                        input logic [19:0] ppn, input logic [5:0] perm,
                        input int ready_dly, input int resp_dly,
                        input int flush_mode, input bit exp_refill);
    int walks0, refills0;
    walks0   = walk_cnt;
    refills0 = refill_cnt;
    l2_tlb_miss  = miss;
    l2_resp_ppn  = miss ? 20'd0 : ppn;
    l2_resp_perm = miss ? 6'd0 : perm;
    if (side_i) begin io_itlb_req_valid = 1'b1; io_itlb_req_vpn = vpn; end
    else begin io_dtlb_req_valid = 1'b1; io_dtlb_req_vpn = vpn; end
    #1;
    check("grant_ready_i", io_itlb_req_ready, side_i);
    check("grant_ready_d", io_dtlb_req_ready, !side_i);
    check("lookup_valid", l2_lookup_valid, 1'b1);
    check("lookup_vpn", l2_lookup_vpn, vpn);
    step();
    io_itlb_req_valid = 1'b0;
    io_dtlb_req_valid = 1'b0;
    #1;
    check("lookup_ready_low", {io_itlb_req_ready, io_dtlb_req_ready}, 2'b00);
    check("lookup_no_resp", {io_itlb_resp_valid, io_dtlb_resp_valid}, 2'b00);
    step();
    if (miss) begin
      for (int d = 0; d <= ready_dly; d++) begin
        io_ptw_req_ready = (d == ready_dly);
        #1;
        check("walk_req_valid", io_ptw_req_valid, 1'b1);
        check("walk_req_addr", io_ptw_req_bits_addr, vpn);
        step();
      end
      io_ptw_req_ready = 1'b0;
      for (int w = 0; w < resp_dly; w++) begin
        io_flush = (flush_mode == 1) && (w == 0);
        #1;
        check("wait_no_resp", {io_itlb_resp_valid, io_dtlb_resp_valid, io_ptw_req_valid}, 3'b000);
        step();
      end
      io_flush = (flush_mode == 2);
      io_ptw_resp_valid = 1'b1;
      io_ptw_resp_bits_pte_ppn = ppn;
      io_ptw_resp_bits_pte_perm = perm;
      step();
      io_flush = 1'b0;
      io_ptw_resp_valid = 1'b0;
      io_ptw_resp_bits_pte_ppn = 20'hFFFFF;
    end
    #1;
    check("resp_valid_i", io_itlb_resp_valid, side_i);
    check("resp_valid_d", io_dtlb_resp_valid, !side_i);
    check("resp_ppn", io_resp_pte_ppn, ppn);
    check("resp_perm", io_resp_pte_perm, perm);
    check("refill_valid", l2_refill_valid, exp_refill);
    check("resp_no_walk", io_ptw_req_valid, 1'b0);
    if (exp_refill) begin
      check("refill_vpn", l2_refill_vpn, vpn);
      check("refill_ppn", l2_refill_ppn, ppn);
      check("refill_perm", l2_refill_perm, perm);
    end
    step();
    #1;
    check("idle_quiet", {io_itlb_resp_valid, io_dtlb_resp_valid, l2_refill_valid}, 3'b000);
    check("walk_count", 64'(walk_cnt - walks0), 64'(miss ? 1 : 0));
    check("refill_count", 64'(refill_cnt - refills0), 64'(exp_refill ? 1 : 0));
  endtask

  initial begin
    reset = 1'b1;
    io_itlb_req_valid = 1'b0; io_itlb_req_vpn = 27'd0;
    io_dtlb_req_valid = 1'b0; io_dtlb_req_vpn = 27'd0;
    l2_tlb_miss = 1'b0; l2_resp_ppn = 20'd0; l2_resp_perm = 6'd0;
    io_ptw_req_ready = 1'b0; io_ptw_resp_valid = 1'b0;
    io_ptw_resp_bits_pte_ppn = 20'd0; io_ptw_resp_bits_pte_perm = 6'd0;
    io_flush = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    #1;
    check("reset_outputs", any_out, 1'b0);
    step();

    // L2 hit from the D-TLB, then a walked miss from the I-TLB.
    do_txn(1'b0, 27'h12345, 1'b0, 20'hABCDE, 6'h3F, 0, 0, 0, 1'b0);
    do_txn(1'b1, 27'h00777, 1'b1, 20'h00042, 6'h1F, 2, 4, 0, 1'b1);

    // Tie fairness from a fresh reset: D, I, D, I.
    reset = 1'b1;
    step();
    reset = 1'b0;
    l2_tlb_miss = 1'b0; l2_resp_ppn = 20'h11111; l2_resp_perm = 6'h01;
    io_dtlb_req_vpn = 27'h0D0D0; io_itlb_req_vpn = 27'h01A1A;
    io_dtlb_req_valid = 1'b1; io_itlb_req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("tie_ready_d", io_dtlb_req_ready, (k % 2) == 0);
      check("tie_ready_i", io_itlb_req_ready, (k % 2) == 1);
      check("tie_lookup_vpn", l2_lookup_vpn, ((k % 2) == 0) ? 27'h0D0D0 : 27'h01A1A);
      step();
      step();
      #1;
      check("tie_resp_d", io_dtlb_resp_valid, (k % 2) == 0);
      check("tie_resp_i", io_itlb_resp_valid, (k % 2) == 1);
      check("tie_resp_ppn", io_resp_pte_ppn, 20'h11111);
      step();
    end
    io_dtlb_req_valid = 1'b0; io_itlb_req_valid = 1'b0;
    step();

    // Flush during walk, flush with the walk response, invalid PTE, then a normal refill.
    do_txn(1'b0, 27'h00ABC, 1'b1, 20'h00099, 6'h1F, 0, 3, 1, 1'b0);
    do_txn(1'b1, 27'h00BCD, 1'b1, 20'h00123, 6'h3F, 1, 2, 2, 1'b0);
    do_txn(1'b0, 27'h00CDE, 1'b1, 20'h00456, 6'h3E, 0, 1, 0, 1'b0);
    do_txn(1'b1, 27'h4000F, 1'b1, 20'h00789, 6'h21, 0, 0, 0, 1'b1);

    // Reset in WALK_WAIT; the late walk response must be ignored.
    l2_tlb_miss = 1'b1;
    io_itlb_req_valid = 1'b1; io_itlb_req_vpn = 27'h05555;
    step();
    io_itlb_req_valid = 1'b0;
    step();
    io_ptw_req_ready = 1'b1;
    step();
    io_ptw_req_ready = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    io_ptw_resp_valid = 1'b1;
    io_ptw_resp_bits_pte_ppn = 20'h00777;
    io_ptw_resp_bits_pte_perm = 6'h3F;
    #1;
    check("midwalk_reset_outputs", any_out, 1'b0);
    step();
    io_ptw_resp_valid = 1'b0;
    #1;
    check("midwalk_late_resp_ignored", any_out, 1'b0);
    step();
    #1;
    check("midwalk_still_quiet", any_out, 1'b0);
    do_txn(1'b0, 27'h00321, 1'b0, 20'h00654, 6'h13, 0, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
